tt_sweep_controller: RTL and testbench

//  Sequencer that characterises one synthesized N_IN-input combinational gate netlist.

---
 rtl/tt_sweep_pkg.sv | 21 ++
 rtl/tt_settle_timer.sv | 38 +++
 rtl/tt_sweep_controller.sv | 148 ++++++++++++++
 tb/tb_tt_sweep_controller.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_sweep_pkg.sv
// rtl/tt_sweep_pkg.sv - shared types and width helpers for the truth-table sweep controller
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Truth-table width for an n-input gate.
    function automatic int tt_width(input int n);
        return 1 << n;
    endfunction

    // Counter width able to hold 0..settle.
    function automatic int timer_width(input int settle);
        return (settle < 1) ? 1 : $clog2(settle + 1);
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// rtl/tt_settle_timer.sv - loadable settle down-counter with expiry flag
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        reloads the counter; the following SETTLE_CYCLES enabled cycles form the window
//   enable      counter runs only while enabled (controller is in APPLY)
//   expired     high during the last cycle of the window
module tt_settle_timer
    import tt_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int CW = timer_width(SETTLE_CYCLES);

    logic [CW-1:0] count;

    // Loaded with SETTLE_CYCLES-1 so that the window covers counts
    // SETTLE_CYCLES-1 down to 0, i.e. exactly SETTLE_CYCLES cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(SETTLE_CYCLES - 1);
        end else if (enable && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    assign expired = enable && (count == '0);

endmodule

// File: rtl/tt_sweep_controller.sv
// rtl/tt_sweep_controller.sv - walks all input vectors of one gate and builds its truth table
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start, abort   sweep control pulses (abort has priority)
//   expected_tt    golden table, latched when a sweep is accepted
//   gate_in        registered drive of the gate primary inputs
//   gate_out       gate primary output (same clock domain, combinational gate)
//   busy, done     status levels
//   observed_tt    captured table, bit i = gate_out sampled with gate_in == i
//   mismatch_mask  observed_tt ^ latched expected, valid when done
//   mismatch       OR-reduce of mismatch_mask, valid when done
module tt_sweep_controller
    import tt_sweep_pkg::*;
#(
    parameter  int N_IN          = 4,
    parameter  int SETTLE_CYCLES = 2,
    localparam int TT_W          = tt_width(N_IN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [TT_W-1:0] expected_tt,
    output logic [N_IN-1:0] gate_in,
    input  logic            gate_out,
    output logic            busy,
    output logic            done,
    output logic [TT_W-1:0] observed_tt,
    output logic [TT_W-1:0] mismatch_mask,
    output logic            mismatch
);

    state_e          state;
    state_e          state_next;
    logic [N_IN-1:0] index;
    logic [TT_W-1:0] exp_q;
    logic [TT_W-1:0] observed_next;
    logic            timer_load;
    logic            timer_expired;
    logic            last_index;

    tt_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (timer_load),
        .enable  (state == ST_APPLY),
        .expired (timer_expired)
    );

    assign last_index = &index;

    // Table including the bit being sampled this cycle, so the final
    // mismatch computation sees the last vector's result.
    always_comb begin
        observed_next        = observed_tt;
        observed_next[index] = gate_out;
    end

    always_comb begin
        state_next = state;
        timer_load = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next = ST_APPLY;
                    timer_load = 1'b1;
                end
            end
            ST_APPLY: begin
                if (timer_expired) begin
                    state_next = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (last_index) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_APPLY;
                    timer_load = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (abort) begin
            state_next = ST_IDLE;
            timer_load = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            index         <= '0;
            exp_q         <= '0;
            gate_in       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            observed_tt   <= '0;
            mismatch_mask <= '0;
            mismatch      <= 1'b0;
        end else begin
            state <= state_next;
            if (abort) begin
                // observed_tt deliberately keeps its partial contents.
                index         <= '0;
                gate_in       <= '0;
                busy          <= 1'b0;
                done          <= 1'b0;
                mismatch_mask <= '0;
                mismatch      <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            exp_q         <= expected_tt;
                            observed_tt   <= '0;
                            mismatch_mask <= '0;
                            mismatch      <= 1'b0;
                            done          <= 1'b0;
                            index         <= '0;
                            gate_in       <= '0;
                            busy          <= 1'b1;
                        end
                    end
                    ST_SAMPLE: begin
                        observed_tt <= observed_next;
                        if (last_index) begin
                            mismatch_mask <= observed_next ^ exp_q;
                            mismatch      <= |(observed_next ^ exp_q);
                            done          <= 1'b1;
                            busy          <= 1'b0;
                            gate_in       <= '0;
                            index         <= '0;
                        end else begin
                            index   <= index + N_IN'(1);
                            gate_in <= index + N_IN'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tt_sweep_controller.sv
// tb/tb_tt_sweep_controller.sv - scoreboard bench for tt_sweep_controller
module tb_tt_sweep_controller;

    localparam int N_IN = 4;
    localparam int TT_W = 16;
    localparam int S0   = 2;
    localparam int S1   = 1;

    typedef struct {
        logic [TT_W-1:0] obs;
        logic [TT_W-1:0] mask;
        logic            mm;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start, start1, abort;
    logic [TT_W-1:0] expected_tt;
    logic [N_IN-1:0] gate_in, gate_in1;
    logic            gate_out, gate_out1;
    logic            busy, busy1, done, done1, mismatch, mismatch1;
    logic [TT_W-1:0] observed_tt, observed_tt1, mismatch_mask, mismatch_mask1;

    int              gate_mode;
    logic [TT_W-1:0] gate_tbl;
    exp_t            sb[$];
    int              checks = 0;
    int              errors = 0;

    always #5 clk = ~clk;

    assign gate_out  = (gate_mode == 0) ? 1'b0 : (gate_mode == 1) ? gate_in[0] : gate_tbl[gate_in];
    assign gate_out1 = gate_in1[0];

    tt_sweep_controller #(.N_IN(N_IN), .SETTLE_CYCLES(S0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected_tt(expected_tt),
        .gate_in(gate_in), .gate_out(gate_out), .busy(busy), .done(done),
        .observed_tt(observed_tt), .mismatch_mask(mismatch_mask), .mismatch(mismatch)
    );

    tt_sweep_controller #(.N_IN(N_IN), .SETTLE_CYCLES(S1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0), .expected_tt(expected_tt),
        .gate_in(gate_in1), .gate_out(gate_out1), .busy(busy1), .done(done1),
        .observed_tt(observed_tt1), .mismatch_mask(mismatch_mask1), .mismatch(mismatch1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic model_bit(input int i);
        logic [3:0] v;
        v = 4'(i);
        if (gate_mode == 0) return 1'b0;
        if (gate_mode == 1) return v[0];
        return gate_tbl[v];
    endfunction

    task automatic pulse_start(input logic [TT_W-1:0] exp_tt);
        @(negedge clk);
        expected_tt = exp_tt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic launch(input logic [TT_W-1:0] exp_tt);
        exp_t e;
        for (int i = 0; i < TT_W; i++) e.obs[i] = model_bit(i);
        e.mask = e.obs ^ exp_tt;
        e.mm   = |e.mask;
        sb.push_back(e);
        pulse_start(exp_tt);
    endtask

    // Called first at the negedge right after the start edge; 'already'
    // counts extra negedges the caller consumed since then.
    task automatic finish_sweep(input string tag, input int already);
        int   lat;
        exp_t e;
        lat = already;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, TT_W * (S0 + 1));
        check({tag, "_sb_has_entry"}, (sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_observed"}, observed_tt, e.obs);
            check({tag, "_mask"}, mismatch_mask, e.mask);
            check({tag, "_mismatch"}, mismatch, e.mm);
            check({tag, "_busy"}, busy, 0);
            check({tag, "_gate_in"}, gate_in, 0);
        end
    endtask

    task automatic wait_index(input string tag, input logic [N_IN-1:0] idx);
        int w;
        w = 0;
        while (gate_in != idx && w < 200) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_reach_index"}, (w < 200), 1);
    endtask

    // gate_in may only step to the next index, and only after a full
    // settle+sample window on the previous one.
    logic [N_IN-1:0] prev_gi;
    logic            prev_busy;
    int              hold;
    always @(negedge clk) begin
        if (!busy) begin
            hold = 0;
        end else if (gate_in != prev_gi) begin
            if (prev_busy) begin
                check("gate_in_step", gate_in, 32'(prev_gi + 4'd1));
                check("gate_in_hold", hold, S0 + 1);
            end
            hold = 1;
        end else begin
            hold++;
        end
        prev_gi   = gate_in;
        prev_busy = busy;
    end

    initial begin
        int lat;
        rst_n = 1'b0; start = 1'b0; start1 = 1'b0; abort = 1'b0;
        expected_tt = '0; gate_mode = 0; gate_tbl = 16'hA7B2;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_gate_in", gate_in, 0);
        check("rst_observed", observed_tt, 0);
        check("rst_mask", mismatch_mask, 0);
        check("rst_mismatch", mismatch, 0);
        rst_n = 1'b1;

        // 1: gate tied low
        gate_mode = 0;
        launch(16'hA7B2);
        finish_sweep("t1", 0);

        // 2: buffer of input 0
        gate_mode = 1;
        launch(16'hAAAA);
        finish_sweep("t2", 0);

        // 2b: shorter settle window on the second instance
        @(negedge clk);
        expected_tt = 16'hAAAA;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        lat = 0;
        while (!done1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("t2b_latency", lat, TT_W * (S1 + 1));
        check("t2b_observed", observed_tt1, 16'hAAAA);
        check("t2b_mismatch", mismatch1, 0);

        // 3: table gate, then expected changed mid-sweep
        gate_mode = 2;
        launch(16'hA7B2);
        finish_sweep("t3", 0);
        launch(16'hA7B2);
        repeat (10) @(negedge clk);
        expected_tt = 16'h0000;
        finish_sweep("t3_latched", 10);

        // 4: start while busy is ignored
        launch(16'hA7B2);
        repeat (7) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_sweep("t4_busy_start", 8);

        // 4: start+abort together from DONE
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("t4_sa_busy", busy, 0);
        check("t4_sa_done", done, 0);
        check("t4_sa_mask", mismatch_mask, 0);

        // 4: abort while index 5 is applied
        pulse_start(16'hA7B2);
        wait_index("t4_abort", 4'd5);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t4_ab_busy", busy, 0);
        check("t4_ab_gate_in", gate_in, 0);
        check("t4_ab_done", done, 0);
        check("t4_ab_mismatch", mismatch, 0);
        check("t4_ab_observed", observed_tt, 16'h0012);
        repeat (3) @(negedge clk);
        check("t4_ab_stays_idle", busy, 0);

        // 5: asynchronous reset mid-sweep
        gate_mode = 1;
        pulse_start(16'hAAAA);
        wait_index("t5", 4'd9);
        #2 rst_n = 1'b0;
        #1;
        check("t5_busy", busy, 0);
        check("t5_gate_in", gate_in, 0);
        check("t5_observed", observed_tt, 0);
        check("t5_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        launch(16'h5555);
        finish_sweep("t5_fresh", 0);

        // 6: back-to-back start from DONE clears results
        gate_mode = 2;
        launch(16'hA7B2);
        check("t6_clr_done", done, 0);
        check("t6_clr_observed", observed_tt, 0);
        check("t6_clr_mask", mismatch_mask, 0);
        check("t6_clr_mismatch", mismatch, 0);
        check("t6_clr_busy", busy, 1);
        finish_sweep("t6", 0);

        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
